pu_mac_engine: RTL and testbench
================================

// Module: pu_mac_engine
// PURPOSE
//  PU-side responder to the pu_control handshake (set_param/enable/read out, *_done back).
//  Latches MAC parameters and runs LANES parallel signed MACs on a streamed operand vector.
//  Presents per-lane results sequentially to the local buffer path. Sits between pu_control and the operand/weight feed.
// PARAMETERS
//  DATA_W   8    signed operand width (data and weight)
//  ACC_W    24   signed accumulator / result width
//  LANES    4    number of parallel MAC lanes
//  LEN_W    8    width of vector-length parameter (K = 1..2^LEN_W-1)
// PORTS
//  i_clk            in   1              clock, all logic on rising edge
//  i_reset          in   1              asynchronous, active-high reset
//  i_terminate      in   1              synchronous abort to IDLE
//  i_set_param      in   1              parameter-load request (level)
//  i_param_len      in   LEN_W          K, beats per MAC run
//  i_param_lanes    in   clog2(LANES)+1 lanes read out, 1..LANES
//  o_set_param_done out  1              parameter ack (level)
//  i_enable         in   1              run request (level; held through READ)
//  i_valid          in   1              operand beat valid
//  i_data           in   DATA_W         broadcast data operand
//  i_weight         in   LANES*DATA_W   per-lane weights, lane l at [l*DATA_W +: DATA_W]
//  o_mac_done       out  1              K beats accumulated (level)
//  i_read           in   1              result readout request (level)
//  o_result_valid   out  1              o_result/o_result_idx valid this cycle
//  o_result         out  ACC_W          accumulator of lane o_result_idx
//  o_result_idx     out  clog2(LANES)   lane index of o_result
//  o_read_done      out  1              readout complete (level)
// BEHAVIOUR
//  Reset (async, i_reset=1): state IDLE; all outputs 0; counters, params, accumulators 0.
//  i_terminate (sync, priority over everything except reset): same values as reset.
//  States: IDLE, PARAM_ACK, READY, MAC, MAC_DONE, READ, READ_DONE.
//  IDLE: i_set_param=1 -> latch len/lanes this edge, go PARAM_ACK; o_set_param_done=1 next cycle.
//  PARAM_ACK: o_set_param_done held 1 until i_set_param=0, then 0 and go READY.
//  Param clamp: len=0 -> 1; lanes=0 -> 1; lanes>LANES -> LANES.
//  READY: i_set_param=1 -> re-latch, PARAM_ACK (priority over enable).
//    i_enable=1 -> clear all acc, beat count=0, go MAC.
//  MAC: each cycle with i_valid=1: acc[l] += sext(data*weight[l]) (signed, 2*DATA_W product), count++.
//    On the K-th valid beat: go MAC_DONE; o_mac_done=1 the following cycle. Further i_valid ignored.
//    i_enable=0 mid-MAC -> abort to READY, acc hold, o_mac_done stays 0.
//  Accumulation wraps modulo 2^ACC_W (no saturation).
//  MAC_DONE: o_mac_done held 1. i_read=1 -> READ with idx=0. i_enable=0 -> READY, clear o_mac_done.
//  READ: one result per cycle, first valid the cycle after i_read sampled 1.
//    o_result_valid=1; o_result=acc[idx]; idx increments 0..lanes-1, no stalls.
//    After idx=lanes-1 -> READ_DONE; o_read_done=1 in the cycle after the last valid; o_result_valid=0.
//  READ_DONE: o_read_done and o_mac_done held until i_read=0 AND i_enable=0 (both drop together in normal flow);
//    then both 0, go READY. Acc retained until next enable.
//  i_read=0 mid-READ -> finish the burst anyway (the burst is atomic).
//  Outputs are all registered; no combinational input->output paths.
// STRUCTURE
//  Shared package pu_pkg: state encoding localparams, DATA_W/ACC_W/LANES defaults, width helpers.
//  Sub-module pu_mac_lane (one per lane, generate loop): clear, en, signed multiply-accumulate, acc out.
//  Top level: FSM, beat counter, param registers, readout mux and index counter.
// TESTING
//  Reset mid-MAC (i_reset pulse at beat 2) -> all outputs 0 immediately; after reset, set_param is required before any MAC.
//  K=4, lanes=2, data 1,2,3,4, w0=1, w1=-2 -> mac_done 1 cycle after 4th beat; results 10 (idx0), -20 (idx1), then read_done.
//  K=3 with i_valid gaps (1,0,1,0,1) and 2 extra beats after the 3rd -> acc reflects exactly 3 beats; extras ignored.
//  DATA_W=8: 127*127 accumulated 1100x, ACC_W=24 -> result equals true sum mod 2^24 (sign-wrapped).
//  Two back-to-back runs without re-param: second enable clears acc -> second results independent of first.
//  i_terminate during READ (idx=1 of 4) -> next cycle IDLE, result_valid=0, read_done=0, set_param_done=0.

Source files
------------

// File: rtl/pu_pkg.sv
// Shared definitions for the PU MAC engine: FSM state encoding, default widths
// and a width helper used for lane-index ports.
package pu_pkg;

  localparam int PU_DATA_W = 8;
  localparam int PU_ACC_W  = 24;
  localparam int PU_LANES  = 4;
  localparam int PU_LEN_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PARAM_ACK = 3'd1,
    ST_READY     = 3'd2,
    ST_MAC       = 3'd3,
    ST_MAC_DONE  = 3'd4,
    ST_READ      = 3'd5,
    ST_READ_DONE = 3'd6
  } pu_state_t;

  // Lane-index width; never collapses to zero bits for a single lane.
  function automatic int pu_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pu_mac_lane.sv
// One signed multiply-accumulate lane. Clear has priority over accumulate;
// the accumulator wraps modulo 2^ACC_W.
module pu_mac_lane #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] data,
  input  logic signed [DATA_W-1:0] weight,
  output logic        [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] product;
  logic        [ACC_W-1:0]    product_ext;
  logic        [ACC_W-1:0]    acc_reg;

  assign product     = data * weight;
  assign product_ext = {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (clear) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_reg + product_ext;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/pu_mac_engine.sv
// PU-side responder for the pu_control handshake: latches run parameters,
// accumulates K operand beats across LANES MAC lanes and streams lane results out.
module pu_mac_engine
  import pu_pkg::*;
#(
  parameter int DATA_W = PU_DATA_W,
  parameter int ACC_W  = PU_ACC_W,
  parameter int LANES  = PU_LANES,
  parameter int LEN_W  = PU_LEN_W
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_terminate,
  input  logic                          i_set_param,
  input  logic [LEN_W-1:0]              i_param_len,
  input  logic [pu_idx_w(LANES):0]      i_param_lanes,
  output logic                          o_set_param_done,
  input  logic                          i_enable,
  input  logic                          i_valid,
  input  logic [DATA_W-1:0]             i_data,
  input  logic [LANES*DATA_W-1:0]       i_weight,
  output logic                          o_mac_done,
  input  logic                          i_read,
  output logic                          o_result_valid,
  output logic [ACC_W-1:0]              o_result,
  output logic [pu_idx_w(LANES)-1:0]    o_result_idx,
  output logic                          o_read_done
);

  localparam int IDX_W = pu_idx_w(LANES);
  localparam int LN_W  = IDX_W + 1;

  pu_state_t         state_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LN_W-1:0]   lanes_reg;
  logic [LEN_W-1:0]  count_reg;
  logic [LN_W-1:0]   rd_ptr_reg;
  logic              set_param_done_reg;
  logic              mac_done_reg;
  logic              result_valid_reg;
  logic [ACC_W-1:0]  result_reg;
  logic [IDX_W-1:0]  result_idx_reg;
  logic              read_done_reg;

  logic [LEN_W-1:0]  len_clamp;
  logic [LN_W-1:0]   lanes_clamp;
  logic              lane_clear;
  logic              lane_en;
  logic [ACC_W-1:0]  lane_acc [LANES];

  assign len_clamp   = (i_param_len == '0) ? LEN_W'(1) : i_param_len;
  assign lanes_clamp = (i_param_lanes == '0)          ? LN_W'(1) :
                       (i_param_lanes > LN_W'(LANES)) ? LN_W'(LANES) : i_param_lanes;

  // Accumulators restart on each new run and on abort; beats only count while enabled.
  assign lane_clear = i_terminate | ((state_reg == ST_READY) & ~i_set_param & i_enable);
  assign lane_en    = (state_reg == ST_MAC) & i_enable & i_valid & ~i_terminate;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      pu_mac_lane #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_lane (
        .clk    (i_clk),
        .rst    (i_reset),
        .clear  (lane_clear),
        .en     (lane_en),
        .data   (i_data),
        .weight (i_weight[gi*DATA_W +: DATA_W]),
        .acc    (lane_acc[gi])
      );
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg          <= ST_IDLE;
      len_reg            <= '0;
      lanes_reg          <= '0;
      count_reg          <= '0;
      rd_ptr_reg         <= '0;
      set_param_done_reg <= 1'b0;
      mac_done_reg       <= 1'b0;
      result_valid_reg   <= 1'b0;
      result_reg         <= '0;
      result_idx_reg     <= '0;
      read_done_reg      <= 1'b0;
    end else if (i_terminate) begin
      state_reg          <= ST_IDLE;
      len_reg            <= '0;
      lanes_reg          <= '0;
      count_reg          <= '0;
      rd_ptr_reg         <= '0;
      set_param_done_reg <= 1'b0;
      mac_done_reg       <= 1'b0;
      result_valid_reg   <= 1'b0;
      result_reg         <= '0;
      result_idx_reg     <= '0;
      read_done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_set_param) begin
            len_reg            <= len_clamp;
            lanes_reg          <= lanes_clamp;
            set_param_done_reg <= 1'b1;
            state_reg          <= ST_PARAM_ACK;
          end
        end
        ST_PARAM_ACK: begin
          if (!i_set_param) begin
            set_param_done_reg <= 1'b0;
            state_reg          <= ST_READY;
          end
        end
        ST_READY: begin
          if (i_set_param) begin
            len_reg            <= len_clamp;
            lanes_reg          <= lanes_clamp;
            set_param_done_reg <= 1'b1;
            state_reg          <= ST_PARAM_ACK;
          end else if (i_enable) begin
            count_reg <= '0;
            state_reg <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (!i_enable) begin
            state_reg <= ST_READY;
          end else if (i_valid) begin
            count_reg <= count_reg + LEN_W'(1);
            if (count_reg == len_reg - LEN_W'(1)) begin
              mac_done_reg <= 1'b1;
              state_reg    <= ST_MAC_DONE;
            end
          end
        end
        ST_MAC_DONE: begin
          if (i_read) begin
            // Lane 0 is presented on the same edge so the first result lands one cycle after read.
            result_valid_reg <= 1'b1;
            result_reg       <= lane_acc[0];
            result_idx_reg   <= '0;
            rd_ptr_reg       <= LN_W'(1);
            state_reg        <= ST_READ;
          end else if (!i_enable) begin
            mac_done_reg <= 1'b0;
            state_reg    <= ST_READY;
          end
        end
        ST_READ: begin
          if (rd_ptr_reg == lanes_reg) begin
            result_valid_reg <= 1'b0;
            read_done_reg    <= 1'b1;
            state_reg        <= ST_READ_DONE;
          end else begin
            result_reg     <= lane_acc[rd_ptr_reg[IDX_W-1:0]];
            result_idx_reg <= rd_ptr_reg[IDX_W-1:0];
            rd_ptr_reg     <= rd_ptr_reg + LN_W'(1);
          end
        end
        ST_READ_DONE: begin
          if (!i_read && !i_enable) begin
            read_done_reg <= 1'b0;
            mac_done_reg  <= 1'b0;
            state_reg     <= ST_READY;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_set_param_done = set_param_done_reg;
  assign o_mac_done       = mac_done_reg;
  assign o_result_valid   = result_valid_reg;
  assign o_result         = result_reg;
  assign o_result_idx     = result_idx_reg;
  assign o_read_done      = read_done_reg;

endmodule

// File: tb/tb_pu_mac_engine.sv
// Directed-sequence bench with randomized operands; expected lane sums come from
// plain integer arithmetic over the driven beats, reduced modulo 2^ACC_W.
module tb_pu_mac_engine;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int LANES  = 4;
  localparam int LEN_W  = 11;
  localparam int MAXB   = 2048;

  logic                    clk = 1'b0;
  logic                    rst, term, set_param, enable, valid, read;
  logic [LEN_W-1:0]        plen;
  logic [2:0]              plan;
  logic [DATA_W-1:0]       data;
  logic [LANES*DATA_W-1:0] weight;
  logic                    set_param_done, mac_done, result_valid, read_done;
  logic [ACC_W-1:0]        result;
  logic [1:0]              result_idx;

  int    checks = 0;
  int    errors = 0;
  int    beat_d [MAXB];
  int    beat_w [MAXB][LANES];
  longint model_acc [LANES];
  int    exp_lanes;

  always #5 clk = ~clk;

  pu_mac_engine #(
    .DATA_W (DATA_W), .ACC_W (ACC_W), .LANES (LANES), .LEN_W (LEN_W)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_terminate      (term),
    .i_set_param      (set_param),
    .i_param_len      (plen),
    .i_param_lanes    (plan),
    .o_set_param_done (set_param_done),
    .i_enable         (enable),
    .i_valid          (valid),
    .i_data           (data),
    .i_weight         (weight),
    .o_mac_done       (mac_done),
    .i_read           (read),
    .o_result_valid   (result_valid),
    .o_result         (result),
    .o_result_idx     (result_idx),
    .o_read_done      (read_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_spd"}, 32'(set_param_done), 0);
    chk({tag, "_macd"}, 32'(mac_done), 0);
    chk({tag, "_rv"}, 32'(result_valid), 0);
    chk({tag, "_res"}, 32'(result), 0);
    chk({tag, "_idx"}, 32'(result_idx), 0);
    chk({tag, "_rdd"}, 32'(read_done), 0);
  endtask

  task automatic set_params(input int len, input int ln);
    set_param = 1'b1;
    plen = LEN_W'(len);
    plan = 3'(ln);
    tick();
    chk("set_param_done_rise", 32'(set_param_done), 1);
    set_param = 1'b0;
    tick();
    chk("set_param_done_fall", 32'(set_param_done), 0);
    exp_lanes = (ln == 0) ? 1 : (ln > LANES) ? LANES : ln;
  endtask

  task automatic fill_random(input int n);
    for (int b = 0; b < n; b++) begin
      beat_d[b] = int'($urandom_range(0, 255)) - 128;
      for (int l = 0; l < LANES; l++) beat_w[b][l] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic drive_beat(input int d, input int w0, input int w1, input int w2, input int w3);
    data = 8'(d);
    weight = {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
  endtask

  task automatic run_mac(input int n, input bit gaps, input int extra);
    enable = 1'b1;
    valid = 1'b0;
    tick();
    for (int l = 0; l < LANES; l++) model_acc[l] = 0;
    for (int b = 0; b < n; b++) begin
      if (gaps && b > 0) begin
        valid = 1'b0;
        drive_beat(int'($urandom_range(0, 255)), 7, 7, 7, 7);
        tick();
        chk("mac_done_gap", 32'(mac_done), 0);
      end
      valid = 1'b1;
      drive_beat(beat_d[b], beat_w[b][0], beat_w[b][1], beat_w[b][2], beat_w[b][3]);
      tick();
      for (int l = 0; l < LANES; l++) model_acc[l] += longint'(beat_d[b]) * longint'(beat_w[b][l]);
      if (b == n - 1) chk("mac_done_last", 32'(mac_done), 1);
      else            chk("mac_done_early", 32'(mac_done), 0);
    end
    for (int e = 0; e < extra; e++) begin
      valid = 1'b1;
      drive_beat(int'($urandom_range(1, 127)), 5, 5, 5, 5);
      tick();
      chk("mac_done_hold", 32'(mac_done), 1);
    end
    valid = 1'b0;
  endtask

  task automatic read_check(input bit drop_read);
    logic [63:0] tmp;
    read = 1'b1;
    tick();
    for (int i = 0; i < exp_lanes; i++) begin
      tmp = 64'(model_acc[i]);
      chk("result_valid", 32'(result_valid), 1);
      chk("result_idx", 32'(result_idx), 32'(i));
      chk("result", 32'(result), {8'd0, tmp[23:0]});
      if (drop_read) read = 1'b0;
      tick();
    end
    chk("result_valid_end", 32'(result_valid), 0);
    chk("read_done_rise", 32'(read_done), 1);
    chk("mac_done_in_read_done", 32'(mac_done), 1);
    read = 1'b0;
    enable = 1'b0;
    tick();
    chk("read_done_fall", 32'(read_done), 0);
    chk("mac_done_fall", 32'(mac_done), 0);
  endtask

  initial begin
    rst = 1'b1; term = 1'b0; set_param = 1'b0; enable = 1'b0; valid = 1'b0; read = 1'b0;
    plen = '0; plan = '0; data = '0; weight = '0;
    #1;
    chk_idle("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // K=4, two lanes, data 1..4 against weights 1 and -2.
    set_params(4, 2);
    for (int b = 0; b < 4; b++) begin
      beat_d[b] = b + 1;
      beat_w[b][0] = 1;
      beat_w[b][1] = -2;
      beat_w[b][2] = 3;
      beat_w[b][3] = -4;
    end
    run_mac(4, 1'b0, 0);
    read_check(1'b0);

    // Gapped valid with extra beats after K, readout with read dropped mid-burst.
    set_params(3, 4);
    fill_random(3);
    run_mac(3, 1'b1, 2);
    read_check(1'b1);

    // Back-to-back run without re-param: acc must restart from zero.
    fill_random(3);
    run_mac(3, 1'b0, 0);
    read_check(1'b0);

    // Enable dropped mid-MAC aborts without mac_done, then a full run.
    set_params(6, 4);
    fill_random(6);
    enable = 1'b1;
    tick();
    valid = 1'b1;
    drive_beat(1, 1, 1, 1, 1);
    tick();
    tick();
    enable = 1'b0;
    valid = 1'b0;
    tick();
    chk("abort_mac_done", 32'(mac_done), 0);
    run_mac(6, 1'b0, 0);
    read_check(1'b0);

    // Clamping of zero length and oversized / zero lane counts.
    set_params(0, 7);
    fill_random(1);
    run_mac(1, 1'b0, 1);
    read_check(1'b0);
    set_params(2, 0);
    fill_random(2);
    run_mac(2, 1'b0, 0);
    read_check(1'b0);

    // Wraparound: 127*127 over 1100 beats with mixed-sign weights.
    set_params(1100, 4);
    for (int b = 0; b < 1100; b++) begin
      beat_d[b] = 127;
      beat_w[b][0] = 127;
      beat_w[b][1] = -127;
      beat_w[b][2] = -128;
      beat_w[b][3] = 1;
    end
    run_mac(1100, 1'b0, 0);
    read_check(1'b0);

    // Terminate while lane 1 of 4 is on the output.
    set_params(5, 4);
    fill_random(5);
    run_mac(5, 1'b0, 0);
    read = 1'b1;
    tick();
    chk("term_pre_idx0", 32'(result_idx), 0);
    tick();
    chk("term_pre_idx1", 32'(result_idx), 1);
    chk("term_pre_valid", 32'(result_valid), 1);
    term = 1'b1;
    tick();
    term = 1'b0;
    read = 1'b0;
    chk_idle("terminate");
    valid = 1'b1;
    repeat (6) tick();
    chk("term_no_mac_without_param", 32'(mac_done), 0);
    enable = 1'b0;
    valid = 1'b0;
    tick();

    // Async reset at beat 2 of a run; parameters must be reloaded afterwards.
    set_params(4, 2);
    fill_random(4);
    enable = 1'b1;
    tick();
    valid = 1'b1;
    drive_beat(beat_d[0], beat_w[0][0], beat_w[0][1], beat_w[0][2], beat_w[0][3]);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk_idle("reset_mid_mac");
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("reset_no_mac_without_param", 32'(mac_done), 0);
    chk("reset_no_param_done", 32'(set_param_done), 0);
    enable = 1'b0;
    valid = 1'b0;
    tick();
    set_params(3, 3);
    fill_random(3);
    run_mac(3, 1'b0, 0);
    read_check(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
